// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: one word fetch per cycle into a DEPTH-entry prefetch FIFO,
// head presented to ID under valid/stall; redirect flushes the queue and drops the in-flight word.
module if_fetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_req,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     stall,
  output logic                     if_valid,
  output logic [31:0]              if_inst,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [ADDR_W-1:0]        if_pc1,
  output logic [3:0]               if_ins_number,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic              run;
  logic              inflight_v;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [31:0]       fifo_inst [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    credit;
  logic              issue;
  logic              push;
  logic              pop;

  // The in-flight fetch holds a reserved slot, so pops are never credited and the FIFO cannot overflow.
  assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v};
  assign issue     = run && (redirect || (credit < DEPTH_C));
  assign push      = inflight_v && !redirect;
  assign pop       = if_valid && !stall && !redirect;

  assign imem_addr = redirect ? redirect_pc : pc;
  assign imem_req  = issue;

  // Fetch issue stage / queue control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      run        <= 1'b0;
      inflight_v <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      run        <= 1'b1;
      inflight_v <= issue;
      if (issue) pc <= imem_addr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (redirect) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Response capture stage: data path carries no reset
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= imem_addr;
    if (push) begin
      fifo_pc[wr_ptr]   <= inflight_pc;
      fifo_inst[wr_ptr] <= imem_data;
    end
  end

  assign if_valid      = (count != '0);
  assign if_inst       = if_valid ? fifo_inst[rd_ptr] : '0;
  assign if_pc         = if_valid ? fifo_pc[rd_ptr] : '0;
  assign if_pc1        = if_valid ? fifo_pc[rd_ptr] + 1'b1 : '0;
  assign if_ins_number = 4'(if_pc);
  assign occupancy     = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stall/redirect/reset traffic.
module tb_if_fetch_queue;

  localparam int                ADDR_W   = 8;
  localparam int                DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  logic                   clk;
  logic                   rst_n;
  logic [ADDR_W-1:0]      imem_addr;
  logic                   imem_req;
  logic [31:0]            imem_data;
  logic                   redirect;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   stall;
  logic                   if_valid;
  logic [31:0]            if_inst;
  logic [ADDR_W-1:0]      if_pc;
  logic [ADDR_W-1:0]      if_pc1;
  logic [3:0]             if_ins_number;
  logic [$clog2(DEPTH):0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc1(if_pc1),
    .if_ins_number(if_ins_number), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of PCs in the FIFO, plus next fetch PC and the one word in flight.
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_inf_pc;
  bit                m_run;
  bit                m_inf_v;
  logic [ADDR_W-1:0] m_q[$];

  always @(negedge clk) begin : cmp
    logic [ADDR_W-1:0] e_pc;
    logic [ADDR_W-1:0] e_pc1;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_inst;
    bit                e_v;
    bit                e_req;
    int                used;
    if (!rst_n) begin
      m_pc    = RESET_PC;
      m_run   = 1'b0;
      m_inf_v = 1'b0;
      m_q.delete();
    end
    e_v    = (m_q.size() != 0);
    e_pc   = e_v ? m_q[0] : '0;
    e_pc1  = e_v ? ADDR_W'(m_q[0] + 1) : '0;
    e_inst = e_v ? mem_word(m_q[0]) : 32'h0;
    used   = m_q.size() + int'(m_inf_v);
    e_req  = m_run && (redirect || used < DEPTH);
    e_addr = redirect ? redirect_pc : m_pc;
    chk("if_valid", 32'(if_valid), 32'(e_v));
    chk("if_pc", 32'(if_pc), 32'(e_pc));
    chk("if_pc1", 32'(if_pc1), 32'(e_pc1));
    chk("if_inst", if_inst, e_inst);
    chk("if_ins_number", 32'(if_ins_number), 32'(e_pc[3:0]));
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    if (rst_n) begin
      if (redirect) begin
        m_q.delete();
      end else begin
        if (e_v && !stall) void'(m_q.pop_front());
        if (m_inf_v) m_q.push_back(m_inf_pc);
      end
      m_inf_v = e_req;
      if (e_req) begin
        m_inf_pc = e_addr;
        m_pc     = ADDR_W'(e_addr + 1);
      end
      m_run = 1'b1;
    end
  end

  logic [ADDR_W-1:0] wrap_pc  [3];
  logic [ADDR_W-1:0] wrap_pc1 [3];
  bit                found;

  initial begin
    wrap_pc[0]  = 8'hFE; wrap_pc[1]  = 8'hFF; wrap_pc[2]  = 8'h00;
    wrap_pc1[0] = 8'hFF; wrap_pc1[1] = 8'h00; wrap_pc1[2] = 8'h01;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    chk("rst_occ", 32'(occupancy), 0);

    // Release: cycle 0 idle, cycle 1 fetch RESET_PC, cycle 3 first valid
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("c0_req", 32'(imem_req), 0);
    step(); @(negedge clk);
    chk("c1_req", 32'(imem_req), 1);
    chk("c1_addr", 32'(imem_addr), 32'h00);
    step(); @(negedge clk);
    chk("c2_valid", 32'(if_valid), 0);
    step(); stall = 1'b1; @(negedge clk);
    chk("c3_valid", 32'(if_valid), 1);
    chk("c3_pc", 32'(if_pc), 32'h00);
    chk("c3_inst", if_inst, mem_word(8'h00));
    chk("c3_pc1", 32'(if_pc1), 32'h01);

    // Stall held for cycles 3..12: queue fills to DEPTH and issue stops
    repeat (9) step();
    @(negedge clk);
    chk("stall_occ", 32'(occupancy), 4);
    chk("stall_req", 32'(imem_req), 0);
    chk("stall_head", 32'(if_pc), 32'h00);
    step(); stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drain_valid", 32'(if_valid), 1);
      chk("drain_pc", 32'(if_pc), 32'(k));
      step();
    end

    // Build occupancy 3 with a fetch in flight, then redirect to 0x40
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() == 3 && m_inf_v) begin found = 1'b1; break; end
      step();
    end
    if (!found) fail_now("wait_occ3");
    stall = 1'b0; redirect = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    chk("redir_occ_before", 32'(occupancy), 3);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    chk("redir_req", 32'(imem_req), 1);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("redir_t1_occ", 32'(occupancy), 0);
    chk("redir_t1_valid", 32'(if_valid), 0);
    step(); @(negedge clk);
    chk("redir_t2_valid", 32'(if_valid), 1);
    chk("redir_t2_pc", 32'(if_pc), 32'h40);
    chk("redir_t2_occ", 32'(occupancy), 1);

    // Address wrap at 2^ADDR_W
    step(); redirect = 1'b1; redirect_pc = 8'hFE;
    step(); redirect = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrap_pc", 32'(if_pc), 32'(wrap_pc[k]));
      chk("wrap_pc1", 32'(if_pc1), 32'(wrap_pc1[k]));
      step();
    end

    // Asynchronous reset mid-stream with two entries queued
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() == 2) begin found = 1'b1; break; end
      step();
    end
    if (!found) fail_now("wait_occ2");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(if_valid), 0);
    chk("arst_inst", if_inst, 0);
    chk("arst_pc", 32'(if_pc), 0);
    chk("arst_pc1", 32'(if_pc1), 0);
    chk("arst_insn", 32'(if_ins_number), 0);
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_req", 32'(imem_req), 0);
    chk("arst_addr", 32'(imem_addr), 32'(RESET_PC));
    step(); stall = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk); chk("rr_c0_req", 32'(imem_req), 0);
    step(); @(negedge clk);
    chk("rr_c1_addr", 32'(imem_addr), 32'(RESET_PC));
    chk("rr_c1_req", 32'(imem_req), 1);
    step(); @(negedge clk);
    chk("rr_c2_valid", 32'(if_valid), 0);
    step(); @(negedge clk);
    chk("rr_c3_valid", 32'(if_valid), 1);
    chk("rr_c3_pc", 32'(if_pc), 32'(RESET_PC));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = ADDR_W'($urandom);
      rst_n       = !($urandom_range(0, 999) < 3);
    end
    step();
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (8) step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
